mem_ctrl: RTL

- Memory controller directly downstream of the store/load buffer (slb) and the instruction fetcher. It owns the single byte-wide RAM/IO port.
- Arbitrates two requesters:
  - instruction fetch: 32-bit word reads.
  - slb: 1/2/4-byte loads and stores.
- Serialises each access into byte cycles and returns one done pulse per request.
- Flush from ROB rollback aborts speculative reads; stores always run to completion.

---
 rtl/mem_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates instruction fetch and the store/load buffer
// over the single byte-wide RAM/IO port and returns one done pulse per request.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | no access in flight; arbitrates slb (first) and ifetch
//   READ   | issuing byte addresses and capturing mem_din
//   WRITE  | driving store bytes with mem_wr high
//   IOWAIT | IO store parked until the IO sink has room
module mem_ctrl #(
   parameter int unsigned ADDR_W = 32,
   parameter logic [1:0]  IO_HI  = 2'b11
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              flush_in,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [31:0]       if_data,
   input  logic              slb_req,
   input  logic              slb_we,
   input  logic [1:0]        slb_len,
   input  logic [ADDR_W-1:0] slb_addr,
   input  logic [31:0]       slb_wdata,
   output logic              slb_done,
   output logic [31:0]       slb_rdata,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, IOWAIT} state_t;

   state_t            state_q, state_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        dout_q, dout_d;
   logic              wr_q, wr_d;
   logic              if_done_q, if_done_d;
   logic              slb_done_q, slb_done_d;
   logic [31:0]       if_data_q, if_data_d;
   logic [31:0]       slb_rdata_q, slb_rdata_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [1:0]        idx_q, idx_d;
   logic [31:0]       cap_word;
   logic [1:0]        slb_last;
   logic              slb_is_io;

   // A length code of 2 has no legal meaning and is widened to a full word.
   assign slb_last  = (slb_len == 2'd2) ? 2'd3 : slb_len;
   assign slb_is_io = (slb_addr[17:16] == IO_HI);

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      addr_d      = addr_q;
      dout_d      = dout_q;
      wr_d        = 1'b0;
      if_done_d   = 1'b0;
      slb_done_d  = 1'b0;
      if_data_d   = if_data_q;
      slb_rdata_d = slb_rdata_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      cap_word    = owner_q ? slb_rdata_q : if_data_q;

      case (state_q)
         IDLE: begin
            if (slb_req && (slb_we || !flush_in)) begin
               owner_d = 1'b1;
               addr_d  = slb_addr;
               wdata_d = slb_wdata;
               cnt_d   = slb_last;
               if (!slb_we) begin
                  state_d = READ;
                  idx_d   = 2'd0;
               end else if (slb_is_io && io_buffer_full) begin
                  state_d = IOWAIT;
                  idx_d   = 2'd0;
               end else begin
                  state_d = WRITE;
                  wr_d    = 1'b1;
                  dout_d  = slb_wdata[7:0];
                  idx_d   = 2'd1;
               end
            end else if (if_req && !flush_in) begin
               owner_d = 1'b0;
               addr_d  = if_addr;
               cnt_d   = 2'd3;
               idx_d   = 2'd0;
               state_d = READ;
            end
         end

         READ: begin
            if (flush_in) begin
               state_d = IDLE;
            end else begin
               // First captured byte also clears the upper bytes so short loads zero-extend.
               if (idx_q == 2'd0) begin
                  cap_word = {24'd0, mem_din};
               end else begin
                  cap_word[{idx_q, 3'b000} +: 8] = mem_din;
               end
               if (owner_q) begin
                  slb_rdata_d = cap_word;
               end else begin
                  if_data_d = cap_word;
               end
               if (cnt_q == 2'd0) begin
                  state_d    = IDLE;
                  slb_done_d = owner_q;
                  if_done_d  = !owner_q;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
                  cnt_d  = cnt_q - 2'd1;
                  idx_d  = idx_q + 2'd1;
               end
            end
         end

         WRITE: begin
            if (cnt_q == 2'd0) begin
               state_d    = IDLE;
               slb_done_d = 1'b1;
            end else begin
               wr_d   = 1'b1;
               addr_d = addr_q + ADDR_W'(1);
               dout_d = wdata_q[{idx_q, 3'b000} +: 8];
               cnt_d  = cnt_q - 2'd1;
               idx_d  = idx_q + 2'd1;
            end
         end

         IOWAIT: begin
            if (!io_buffer_full) begin
               state_d = WRITE;
               wr_d    = 1'b1;
               dout_d  = wdata_q[7:0];
               idx_d   = 2'd1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         addr_q      <= '0;
         dout_q      <= 8'd0;
         wr_q        <= 1'b0;
         if_done_q   <= 1'b0;
         slb_done_q  <= 1'b0;
         if_data_q   <= 32'd0;
         slb_rdata_q <= 32'd0;
         wdata_q     <= 32'd0;
         cnt_q       <= 2'd0;
         idx_q       <= 2'd0;
      end else if (rdy_in) begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         addr_q      <= addr_d;
         dout_q      <= dout_d;
         wr_q        <= wr_d;
         if_done_q   <= if_done_d;
         slb_done_q  <= slb_done_d;
         if_data_q   <= if_data_d;
         slb_rdata_q <= slb_rdata_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
      end
   end

   // A stalled write must not reach the RAM even though the registered strobe holds.
   assign mem_wr    = wr_q & rdy_in;
   assign mem_a     = addr_q;
   assign mem_dout  = dout_q;
   assign if_done   = if_done_q;
   assign slb_done  = slb_done_q;
   assign if_data   = if_data_q;
   assign slb_rdata = slb_rdata_q;

endmodule
